wb_cmd_master: RTL and testbench

//  Wishbone classic master that sits directly upstream of the UART's Wishbone slave port and drives its bus.

---
 rtl/wb_cmd_pkg.sv | 19 +
 rtl/wb_cmd_fifo.sv | 49 ++++
 rtl/wb_cmd_master.sv | 170 +++++++++++++++++
 tb/tb_wb_cmd_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_cmd_pkg.sv
// Shared types and widths for the Wishbone command master and its command FIFO.
package wb_cmd_pkg;

  localparam int unsigned AddrW = 3;
  localparam int unsigned DataW = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RSP
  } wbm_state_e;

  typedef struct packed {
    logic             we;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
  } wb_cmd_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO: wrapping pointers plus an occupancy count for full/empty.
module wb_cmd_fifo
  import wb_cmd_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic    clk,
  input  logic    rst_ni,
  input  logic    push_i,
  input  wb_cmd_t wdata_i,
  input  logic    pop_i,
  output wb_cmd_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  wb_cmd_t         mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic master: queued register commands, one bus cycle at a time with ack timeout,
// responses over valid/ready, plus a registered interrupt with rise pulse.
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [3:0]  SEL_VAL   = 4'hF
) (
  input  logic             clk,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [AddrW-1:0] cmd_addr,
  input  logic [DataW-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_we,
  output logic [DataW-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [AddrW-1:0] wb_adr_o,
  output logic [DataW-1:0] wb_dat_o,
  input  logic [DataW-1:0] wb_dat_i,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_stb_o,
  output logic             wb_cyc_o,
  input  logic             wb_ack_i,
  input  logic             wb_int_i,
  output logic             irq_o,
  output logic             irq_rise_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  wbm_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AddrW-1:0] adr_q, adr_d;
  logic [DataW-1:0] dat_q, dat_d;
  logic [3:0]       sel_q, sel_d;
  logic             we_q, we_d, stb_q, stb_d, cyc_q, cyc_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d, rsp_err_q, rsp_err_d;
  logic [DataW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             irq_q, irq_rise_q;

  wb_cmd_t cmd_in, cmd_head;
  logic    fifo_full, fifo_empty, fifo_pop;

  assign cmd_in = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};

  wb_cmd_fifo #(
    .Depth (CMD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (wb_rst_ni),
    .push_i  (cmd_valid),
    .wdata_i (cmd_in),
    .pop_i   (fifo_pop),
    .rdata_o (cmd_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    stb_d       = stb_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          adr_d   = cmd_head.addr;
          dat_d   = cmd_head.wdata;
          we_d    = cmd_head.we;
          sel_d   = SEL_VAL;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack is checked first so an ack on the last allowed cycle still completes cleanly.
        if (wb_ack_i || cnt_q == CntLast) begin
          rsp_valid_d = 1'b1;
          rsp_we_d    = we_q;
          rsp_err_d   = ~wb_ack_i;
          rsp_rdata_d = (wb_ack_i && !we_q) ? wb_dat_i : '0;
          fifo_pop    = 1'b1;
          stb_d       = 1'b0;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = '0;
          state_d     = RSP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      stb_q       <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      irq_q       <= 1'b0;
      irq_rise_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      stb_q       <= stb_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      irq_q       <= wb_int_i;
      irq_rise_q  <= wb_int_i & ~irq_q;
    end
  end

  assign cmd_ready  = ~fifo_full;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_we     = rsp_we_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign wb_we_o    = we_q;
  assign wb_stb_o   = stb_q;
  assign wb_cyc_o   = cyc_q;
  assign irq_o      = irq_q;
  assign irq_rise_o = irq_rise_q;
  assign busy_o     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: vector table of single commands plus hand-written sequences
// for FIFO back-pressure, mid-cycle reset and the interrupt path.
module tb_wb_cmd_master;

  logic       clk = 1'b0;
  logic       wb_rst_ni = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [2:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_we, rsp_err;
  logic [7:0] rsp_rdata;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o, wb_dat_i = '0;
  logic [3:0] wb_sel_o;
  logic       wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
  logic       wb_int_i = 1'b0, irq_o, irq_rise_o, busy_o;

  // Slave model: ack after stb has been high for ack_lat cycles (0 = first bus cycle).
  logic       ack_en = 1'b0, ack_force = 1'b0;
  logic [7:0] ack_lat = '0, stb_age = '0;
  assign wb_ack_i = ack_force | (ack_en & wb_stb_o & (stb_age == ack_lat));
  always @(posedge clk) stb_age <= wb_stb_o ? stb_age + 8'd1 : 8'd0;

  logic [7:0] bus_log[$];
  always @(negedge clk) if (wb_stb_o && wb_ack_i) bus_log.push_back(wb_dat_o);

  always #5 clk = ~clk;

  wb_cmd_master #(
    .CMD_DEPTH (4),
    .TIMEOUT   (16),
    .SEL_VAL   (4'hF)
  ) dut (
    .clk        (clk),
    .wb_rst_ni  (wb_rst_ni),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_we     (rsp_we),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i),
    .wb_int_i   (wb_int_i),
    .irq_o      (irq_o),
    .irq_rise_o (irq_rise_o),
    .busy_o     (busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] sdata;     // slave read data
    logic [7:0] lat;       // ack latency, 8'hFF = never
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_stb;   // cycles stb stays high
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    ack_en    = (v.lat != 8'hFF);
    ack_lat   = v.lat;
    wb_dat_i  = v.sdata;
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    chk("vec_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("vec_stb_not_yet", 32'(wb_stb_o), 32'd0);
    @(negedge clk);
    chk("vec_stb_latency", 32'(wb_stb_o), 32'd1);
    chk("vec_cyc", 32'(wb_cyc_o), 32'd1);
    chk("vec_adr", 32'(wb_adr_o), 32'(v.addr));
    chk("vec_dat", 32'(wb_dat_o), 32'(v.wdata));
    chk("vec_we", 32'(wb_we_o), 32'(v.we));
    chk("vec_sel", 32'(wb_sel_o), 32'hF);
    n = 0;
    while (wb_stb_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("vec_stb_cycles", 32'(n), 32'(v.exp_stb));
    chk("vec_cyc_drop", 32'(wb_cyc_o), 32'd0);
    chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("vec_rsp_we", 32'(rsp_we), 32'(v.we));
    chk("vec_rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("vec_rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("vec_rsp_done", 32'(rsp_valid), 32'd0);
    chk("vec_idle", 32'(busy_o), 32'd0);
    ack_en = 1'b0;
  endtask

  initial begin
    int accepted, nrsp, base, k;
    bit pending;

    vecs[0] = '{1'b1, 3'd3, 8'h83, 8'h00, 8'd1,   8'h00, 1'b0, 2};
    vecs[1] = '{1'b0, 3'd0, 8'h00, 8'h5A, 8'd0,   8'h5A, 1'b0, 1};
    vecs[2] = '{1'b0, 3'd5, 8'h00, 8'h77, 8'hFF,  8'h00, 1'b1, 16};
    vecs[3] = '{1'b0, 3'd7, 8'h00, 8'h3C, 8'd15,  8'h3C, 1'b0, 16};
    vecs[4] = '{1'b1, 3'd1, 8'h42, 8'h99, 8'd0,   8'h00, 1'b0, 1};
    vecs[5] = '{1'b0, 3'd2, 8'h00, 8'hA5, 8'd3,   8'hA5, 1'b0, 4};

    // Reset state
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_outputs", 32'({rsp_valid, rsp_we, rsp_err, rsp_rdata, wb_adr_o, wb_dat_o, wb_sel_o,
                            wb_we_o, wb_stb_o, wb_cyc_o, irq_o, irq_rise_o, busy_o}), 32'd0);
    @(negedge clk);
    wb_rst_ni = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure: responses stalled, six immediate-ack writes offered back to back
    ack_en  = 1'b1;
    ack_lat = 8'd0;
    base    = bus_log.size();
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_addr  = 3'(i);
      cmd_wdata = 8'h10 + 8'(i);
      if (cmd_ready) accepted++;
    end
    @(negedge clk);
    cmd_addr  = 3'd5;
    cmd_wdata = 8'h15;
    chk("bp_accepted", 32'(accepted), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready_low", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    chk("bp_busy", 32'(busy_o), 32'd1);
    chk("bp_rsp_stalled", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    nrsp = 0;
    pending = 1'b1;
    for (int c = 0; c < 80 && (nrsp < 6 || pending); c++) begin
      if (rsp_valid) begin
        nrsp++;
        chk("bp_rsp_fields", 32'({rsp_we, rsp_err, rsp_rdata}), 32'h200);
      end
      if (pending && cmd_ready) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        pending = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    rsp_ready = 1'b0;
    chk("bp_rsp_count", 32'(nrsp), 32'd6);
    chk("bp_bus_count", 32'(bus_log.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      k = base + i;
      if (k < bus_log.size()) chk("bp_bus_order", 32'(bus_log[k]), 32'h10 + 32'(i));
    end
    chk("bp_idle", 32'(busy_o), 32'd0);

    // Reset in the middle of a read bus cycle, with a second command queued
    ack_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 3'd4;
    @(negedge clk);
    cmd_addr  = 3'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mr_in_bus", 32'(wb_stb_o), 32'd1);
    #2 wb_rst_ni = 1'b0;
    #1;
    chk("mr_async_drop", 32'({wb_cyc_o, wb_stb_o, rsp_valid}), 32'd0);
    @(negedge clk);
    wb_rst_ni = 1'b1;
    @(negedge clk);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mr_busy", 32'(busy_o), 32'd0);
    k = 0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid || wb_stb_o) k++;
      @(negedge clk);
    end
    chk("mr_no_activity", 32'(k), 32'd0);

    // Interrupt path, and a stray ack while idle
    wb_int_i = 1'b1;
    chk("irq_before", 32'({irq_o, irq_rise_o}), 32'd0);
    @(negedge clk);
    chk("irq_rise", 32'({irq_o, irq_rise_o}), 32'b11);
    ack_force = 1'b1;
    @(negedge clk);
    chk("irq_held", 32'({irq_o, irq_rise_o}), 32'b10);
    ack_force = 1'b0;
    chk("idle_ack_ignored", 32'({busy_o, rsp_valid, wb_stb_o}), 32'd0);
    @(negedge clk);
    chk("irq_no_repulse", 32'(irq_rise_o), 32'd0);
    wb_int_i = 1'b0;
    @(negedge clk);
    chk("irq_fall", 32'({irq_o, irq_rise_o}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
